// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM pin and the capture block: raw input in,
// period/high-time measurement and status out.
interface pwm_capture_if #(
  parameter int unsigned CTR_LEN = 8
);
  logic               pwm_in;
  logic [CTR_LEN-1:0] period;
  logic [CTR_LEN-1:0] high_time;
  logic               valid;
  logic               timeout;
  logic               level;

  modport master (
    output pwm_in,
    input  period, high_time, valid, timeout, level
  );

  modport slave (
    input  pwm_in,
    output period, high_time, valid, timeout, level
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clock cycles,
// with a one-cycle valid strobe per period and a timeout when edges stop.
module pwm_capture #(
  parameter int unsigned CTR_LEN = 8
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.slave  bus
);

  typedef enum logic {IDLE, MEAS} state_e;

  localparam logic [CTR_LEN-1:0] MAX = '1;
  localparam logic [CTR_LEN-1:0] ONE = {{(CTR_LEN-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic               s1_q, s2_q, s3_q;
  logic [CTR_LEN-1:0] per_ctr_q, per_ctr_d;
  logic [CTR_LEN-1:0] hi_ctr_q, hi_ctr_d;
  logic [CTR_LEN-1:0] period_q, period_d;
  logic [CTR_LEN-1:0] high_q, high_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               rise;

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (rise) begin
      per_ctr_d = ONE;
      hi_ctr_d  = ONE;
    end else begin
      per_ctr_d = (per_ctr_q == MAX) ? per_ctr_q : per_ctr_q + ONE;
      hi_ctr_d  = (s2_q && hi_ctr_q != MAX) ? hi_ctr_q + ONE : hi_ctr_q;
    end

    // A rise in the same cycle the period counter saturates still counts as a
    // measurement of exactly MAX, so rise is tested before the timeout.
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = MEAS;
          timeout_d = 1'b0;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d = per_ctr_q;
          high_d   = hi_ctr_q;
          valid_d  = 1'b1;
        end else if (per_ctr_q == MAX) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      per_ctr_q <= '0;
      hi_ctr_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= bus.pwm_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      per_ctr_q <= per_ctr_d;
      hi_ctr_q  <= hi_ctr_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.level     = s2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: an input-side model queues the expected
// measurement at each driven rising edge; the monitor pops on every valid.
module tb_pwm_capture;

  localparam int unsigned CTR_LEN = 8;
  localparam int unsigned MAXV    = 255;

  typedef struct {
    logic [7:0] per;
    logic [7:0] hi;
  } meas_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwm_capture_if #(.CTR_LEN(CTR_LEN)) bus ();

  pwm_capture #(.CTR_LEN(CTR_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Input-domain model of the measurement.
  meas_t       exp_q[$];
  logic        m_prev  = 1'b0;
  logic        m_armed = 1'b0;
  int unsigned m_cnt   = 0;
  int unsigned m_hcnt  = 0;
  int unsigned n_push  = 0;

  task automatic drive(input logic v);
    meas_t e;
    @(negedge clk);
    bus.pwm_in = v;
    if (v && !m_prev) begin
      if (m_armed) begin
        e.per = 8'(m_cnt);
        e.hi  = 8'(m_hcnt);
        exp_q.push_back(e);
        n_push++;
      end
      m_armed = 1'b1;
      m_cnt   = 1;
      m_hcnt  = 1;
    end else begin
      if (m_armed && m_cnt == MAXV) m_armed = 1'b0;
      if (m_cnt < MAXV) m_cnt++;
      if (v && m_hcnt < MAXV) m_hcnt++;
    end
    m_prev = v;
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    repeat (hi) drive(1'b1);
    repeat (lo) drive(1'b0);
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      bus.pwm_in = ~bus.pwm_in;
    end
    check("rst_period", bus.period, 0);
    check("rst_high_time", bus.high_time, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_level", bus.level, 0);
    check("sb_drain_at_reset", exp_q.size(), 0);
    exp_q.delete();
    m_prev  = 1'b0;
    m_armed = 1'b0;
    m_cnt   = 0;
    m_hcnt  = 0;
    @(negedge clk);
    rst        = 1'b0;
    bus.pwm_in = 1'b0;
  endtask

  // Monitor
  int unsigned n_valid    = 0;
  int unsigned since      = 0;
  logic        seen_valid = 1'b0;
  logic        prev_to    = 1'b0;
  logic        to_chk     = 1'b0;
  logic        to_seen    = 1'b0;
  logic        no_to_chk  = 1'b0;

  always @(negedge clk) begin
    meas_t e;
    if (rst) begin
      seen_valid = 1'b0;
      prev_to    = 1'b0;
    end else begin
      if (bus.valid) begin
        check("valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("period", bus.period, e.per);
          check("high_time", bus.high_time, e.hi);
        end
        if (seen_valid) check("valid_gap_ge2", (since + 1) >= 2, 1);
        seen_valid = 1'b1;
        since      = 0;
        n_valid++;
      end else begin
        since++;
      end
      if (to_chk && bus.timeout && !prev_to) begin
        check("timeout_after_last_rise", since, MAXV);
        to_seen = 1'b1;
      end
      if (no_to_chk) check("timeout_low_period255", bus.timeout, 0);
      prev_to = bus.timeout;
    end
  end

  int unsigned n0;
  logic [2:0]  g;

  initial begin
    bus.pwm_in = 1'b0;

    do_reset(2);

    // Steady high 3 / low 5
    repeat (6) pulse(3, 5);

    // Loopback of a 3-bit PWM generator with compare 5
    g = '0;
    repeat (40) begin
      drive(g < 3'd5);
      g = g + 3'd1;
    end

    // Minimum period
    repeat (10) pulse(1, 1);

    // Period of exactly MAX
    no_to_chk = 1'b1;
    repeat (3) pulse(10, 245);
    no_to_chk = 1'b0;

    // Period of MAX+1
    n0 = n_valid;
    pulse(10, 246);
    pulse(10, 246);
    repeat (10) drive(1'b0);
    check("timeout_period256", bus.timeout, 1);
    check("no_valid_period256", n_valid - n0, 1);

    // Stuck high after steady PWM
    repeat (5) pulse(3, 5);
    to_chk = 1'b1;
    repeat (300) drive(1'b1);
    to_chk = 1'b0;
    check("timeout_stuck", bus.timeout, 1);
    check("timeout_edge_seen", to_seen, 1);
    check("period_hold", bus.period, 8);
    check("high_time_hold", bus.high_time, 3);

    // Resume: level and timeout latency around the first rise
    repeat (5) drive(1'b0);
    drive(1'b1);
    drive(1'b1);
    check("level_lat1", bus.level, 0);
    drive(1'b1);
    check("level_lat2", bus.level, 1);
    check("timeout_before_clear", bus.timeout, 1);
    drive(1'b0);
    check("timeout_cleared", bus.timeout, 0);
    repeat (4) drive(1'b0);
    repeat (3) pulse(3, 5);

    // Reset mid-measurement
    repeat (2) pulse(3, 5);
    pulse(3, 4);
    do_reset(2);
    n0 = n_valid;
    pulse(3, 5);
    check("no_valid_after_first_rise", n_valid - n0, 0);
    repeat (3) pulse(3, 5);
    repeat (8) drive(1'b0);
    check("valid_after_reset", n_valid - n0, 3);

    check("sb_empty", exp_q.size(), 0);
    check("valid_count", n_valid, n_push);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
